modulo_buffer_contagem: RTL and testbench
=========================================

# modulo_buffer_contagem

Input buffer stage directly upstream of the counter-control FSM. It queues count values written by the input logic in a small FIFO and presents the oldest value in a holding register. It drives the FSM's `Load_Reg` (holding register valid) and `EmptyBuffer` (no further values queued) inputs. It releases the holding register when the FSM asserts `Clear_Reg`.

## Interface
- `WIDTH`, default 8: bits per count value.
- `DEPTH`, default 4: FIFO entries, excluding the holding register. Must be a power of two, ≥2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global enable, shared with the FSM. When low, all state holds, including the `Clear_Reg` response.
- `wr_en`  in  1  push request; sampled on each enabled edge.
- `data_in`  in  WIDTH  value to push.
- `Clear_Reg`  in  1  from the FSM; consume and clear the holding register.
- `data_out`  out  WIDTH  holding register contents, to the counter load input.
- `Load_Reg`  out  1  holding register holds a valid value.
- `EmptyBuffer`  out  1  FIFO storage count == 0.
- `Full`  out  1  FIFO storage count == DEPTH.
- `overflow`  out  1  sticky overflow flag; see Configuration.

## Operation
- Storage:
  - DEPTH-entry circular memory.
  - Read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count register, log2(DEPTH)+1 bits.
  - Holding register `data_out` with valid bit `Load_Reg`.
- Push: if `wr_en` and count < DEPTH (pre-edge value), write `data_in` at the write pointer and increment the pointer.
- Push when full: if `wr_en` and count == DEPTH, the push is dropped. Memory, pointers and count are unchanged.
- Refill: if the holding register is free after this edge's `Clear_Reg` and count > 0 (pre-edge), move the head entry into `data_out`, set `Load_Reg`, and increment the read pointer.
  - Free means `Load_Reg` == 0, or `Clear_Reg` == 1.
  - Refill and clear in the same edge give back-to-back delivery.
- Clear: if `Clear_Reg` and no refill, `Load_Reg` goes to 0 and `data_out` goes to 0.
  - `Clear_Reg` while `Load_Reg` == 0 has no effect.
- Simultaneous push and refill: count is unchanged. Both pointers advance.
- Push into an empty FIFO never bypasses memory. The value reaches the holding register on the following edge.
- `enable` low: no push, refill, clear or overflow update. Inputs are ignored.
- Reset, including mid-operation:
  - `data_out` = 0, `Load_Reg` = 0, `EmptyBuffer` = 1, `Full` = 0, `overflow` = 0.
  - Pointers and count = 0.
  - Memory contents are don't-care.
  - Reset overrides all other inputs, including `enable` low.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational input-to-output path.
- Push into an idle, empty block:
  - Edge N: entry stored; `EmptyBuffer` falls after edge N.
  - Edge N+1: refill; `Load_Reg` rises and `EmptyBuffer` returns to 1.
- `Clear_Reg` at edge M with ≥1 queued: new `data_out` valid after edge M, with no gap cycle.
- `Clear_Reg` at edge M with count 0: `Load_Reg` low after edge M.
- `Full` and `EmptyBuffer` reflect the post-edge count.
- Maximum values in flight: DEPTH+1.

## Configuration
- Macro: `BUFFER_OVERFLOW_FLAG_EN`.
- Defined: `overflow` is set on any enabled edge with `wr_en` && count == DEPTH (pre-edge). It stays set until `rst`.
- Undefined: the overflow register is not built. `overflow` is tied to 0. Dropped pushes are silent.

## Structure
- Shared package `pkg_contador` holds:
  - `BUF_WIDTH` = 8 and `BUF_DEPTH` = 4.
  - The derived pointer width `BUF_PTR_W` = 2.
  - The FIFO status typedef: struct of empty, full, count.
- Sub-module `modulo_fifo_mem`: DEPTH×WIDTH register-file memory with synchronous write port and asynchronous read port.
- Pointers, count, holding register and overflow logic live in the top module.

## Test plan
- Reset then idle:
  - `data_out` = 0, `Load_Reg` = 0, `EmptyBuffer` = 1, `Full` = 0, `overflow` = 0.
  - All hold for 10 cycles.
- Single push 0x2A at edge N: `EmptyBuffer` = 0 after N; `Load_Reg` = 1 and `data_out` = 0x2A after N+1.
- Fill and drain:
  - Push 0x01..0x05 on consecutive edges with `Clear_Reg` low: `Load_Reg` = 1, `data_out` = 0x01, `Full` = 1.
  - Then pulse `Clear_Reg` each cycle: `data_out` steps 0x02, 0x03, 0x04, 0x05, then `Load_Reg` = 0.
- Overflow:
  - With `Full` = 1, push 0x99: entry dropped; 0x99 is never presented on `data_out`.
  - `overflow` = 1 with the macro defined, 0 without.
- Simultaneous push, refill and clear at count 1: count stays 1, `data_out` advances, and the pushed value appears after the next clear.
- Mid-operation control:
  - `enable` low for 3 cycles during pushes and clears: no state change.
  - `rst` mid-drain: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/modulo_buffer_contagem_pkg.sv
// Shared constants and types for the counter input buffer.
package pkg_contador;

    localparam int BUF_WIDTH = 8;
    localparam int BUF_DEPTH = 4;
    localparam int BUF_PTR_W = 2;

    typedef struct packed {
        logic                 empty;
        logic                 full;
        logic [BUF_PTR_W:0]   count;
    } fifo_status_t;

endpackage

// File: rtl/modulo_buffer_contagem_fifo_mem.sv
// Register-file FIFO storage: synchronous write port, asynchronous read port.
module modulo_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/modulo_buffer_contagem.sv
// Input buffer feeding the counter FSM: FIFO plus holding register.
// Optional sticky overflow flag built when BUFFER_OVERFLOW_FLAG_EN is defined.
module modulo_buffer_contagem
    import pkg_contador::*;
#(
    parameter int WIDTH = BUF_WIDTH,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             Clear_Reg,
    output logic [WIDTH-1:0] data_out,
    output logic             Load_Reg,
    output logic             EmptyBuffer,
    output logic             Full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] head;
    logic             push_ok;
    logic             refill;
    logic             mem_we;

    assign push_ok = wr_en && (count != FULL_CNT);
    // Holding register is free if empty or being consumed on this edge.
    assign refill  = (!Load_Reg || Clear_Reg) && (count != '0);
    assign mem_we  = !rst && enable && push_ok;

    modulo_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            Load_Reg <= 1'b0;
        end else if (enable) begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (refill) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= head;
                Load_Reg <= 1'b1;
            end else if (Clear_Reg) begin
                data_out <= '0;
                Load_Reg <= 1'b0;
            end
            case ({push_ok, refill})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign EmptyBuffer = (count == '0);
    assign Full        = (count == FULL_CNT);

`ifdef BUFFER_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (enable && wr_en && (count == FULL_CNT))
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_modulo_buffer_contagem.sv
// Table-driven bench with a delivery-order scoreboard for modulo_buffer_contagem.
module tb_modulo_buffer_contagem;

`ifdef BUFFER_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, enable, wr_en, Clear_Reg;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       Load_Reg, EmptyBuffer, Full, overflow;

    always #5 clk = ~clk;

    modulo_buffer_contagem dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .Clear_Reg   (Clear_Reg),
        .data_out    (data_out),
        .Load_Reg    (Load_Reg),
        .EmptyBuffer (EmptyBuffer),
        .Full        (Full),
        .overflow    (overflow)
    );

    typedef struct {
        logic       rst, en, wr;
        logic [7:0] din;
        logic       clr;
        logic       load;
        logic [7:0] dout;
        logic       empty, full, ovf;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   failures = 0;

    // scoreboard: accepted values in FIFO order, plus holding-register model
    logic [7:0] sb_q[$];
    bit         sb_hold = 1'b0;

    task automatic add(input logic r, input logic e, input logic w, input logic [7:0] d,
                       input logic c, input logic ld, input logic [7:0] dq,
                       input logic em, input logic fu, input logic ov);
        vec_t v;
        v.rst = r; v.en = e; v.wr = w; v.din = d; v.clr = c;
        v.load = ld; v.dout = dq; v.empty = em; v.full = fu; v.ovf = ov;
        tv.push_back(v);
    endtask

    task automatic step(input int idx, input vec_t v);
        bit         deliver;
        logic [7:0] exp_val;
        logic [4:0] exp_vec, act_vec;
        int         pre_size;
        rst = v.rst; enable = v.en; wr_en = v.wr; data_in = v.din; Clear_Reg = v.clr;
        deliver = 1'b0;
        exp_val = '0;
        if (v.rst) begin
            sb_q.delete();
            sb_hold = 1'b0;
        end else if (v.en) begin
            pre_size = sb_q.size();
            if ((!sb_hold || v.clr) && pre_size > 0) begin
                exp_val = sb_q.pop_front();
                deliver = 1'b1;
                sb_hold = 1'b1;
            end else if (v.clr) begin
                sb_hold = 1'b0;
            end
            if (v.wr && pre_size < DEPTH) sb_q.push_back(v.din);
        end
        @(posedge clk);
        #1;
        exp_vec = {v.load, v.empty, v.full, v.ovf & OVF_EN, 1'b0};
        act_vec = {Load_Reg, EmptyBuffer, Full, overflow, 1'b0};
        checks++;
        if (act_vec !== exp_vec || data_out !== v.dout) begin
            failures++;
            $display("FAIL row%0d flags{load,empty,full,ovf}: got %b dout=%h, expected %b dout=%h",
                     idx, act_vec[4:1], data_out, exp_vec[4:1], v.dout);
        end
        if (deliver) begin
            checks++;
            if (Load_Reg !== 1'b1 || data_out !== exp_val) begin
                failures++;
                $display("FAIL sb_delivery row%0d: got load=%b data=%h, expected load=1 data=%h",
                         idx, Load_Reg, data_out, exp_val);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; wr_en = 1'b0; data_in = '0; Clear_Reg = 1'b0;
        //   rst en wr din    clr  load dout   emp full ovf
        add(1, 1, 0, 8'h00, 0,   0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 0, 8'h00, 0,   0, 8'h00, 1, 0, 0);
        // single push
        add(0, 1, 1, 8'h2A, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 0, 8'h00, 0,   1, 8'h2A, 1, 0, 0);
        add(0, 1, 0, 8'h00, 1,   0, 8'h00, 1, 0, 0);
        // fill
        add(0, 1, 1, 8'h01, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h02, 0,   1, 8'h01, 0, 0, 0);
        add(0, 1, 1, 8'h03, 0,   1, 8'h01, 0, 0, 0);
        add(0, 1, 1, 8'h04, 0,   1, 8'h01, 0, 0, 0);
        add(0, 1, 1, 8'h05, 0,   1, 8'h01, 0, 1, 0);
        // push while full is dropped
        add(0, 1, 1, 8'h99, 0,   1, 8'h01, 0, 1, 1);
        // drain
        add(0, 1, 0, 8'h00, 1,   1, 8'h02, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'h03, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'h04, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'h05, 1, 0, 1);
        add(0, 1, 0, 8'h00, 1,   0, 8'h00, 1, 0, 1);
        // push + refill + clear at count 1
        add(0, 1, 1, 8'hAA, 0,   0, 8'h00, 0, 0, 1);
        add(0, 1, 1, 8'hBB, 0,   1, 8'hAA, 0, 0, 1);
        add(0, 1, 1, 8'hCC, 1,   1, 8'hBB, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'hCC, 1, 0, 1);
        add(0, 1, 0, 8'h00, 1,   0, 8'h00, 1, 0, 1);
        // enable low holds everything
        add(0, 1, 1, 8'h11, 0,   0, 8'h00, 0, 0, 1);
        add(0, 0, 1, 8'h22, 1,   0, 8'h00, 0, 0, 1);
        add(0, 0, 1, 8'h23, 1,   0, 8'h00, 0, 0, 1);
        add(0, 0, 1, 8'h24, 1,   0, 8'h00, 0, 0, 1);
        add(0, 1, 0, 8'h00, 0,   1, 8'h11, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1,   1, 8'h11, 1, 0, 1);
        // reset mid-drain, overriding enable low
        add(0, 1, 1, 8'h33, 0,   1, 8'h11, 0, 0, 1);
        add(0, 1, 1, 8'h44, 0,   1, 8'h11, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'h33, 0, 0, 1);
        add(0, 1, 0, 8'h00, 1,   1, 8'h44, 1, 0, 1);
        add(0, 1, 1, 8'h55, 0,   1, 8'h44, 0, 0, 1);
        add(1, 0, 1, 8'h66, 1,   0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0,   0, 8'h00, 1, 0, 0);

        for (int i = 0; i < tv.size(); i++) step(i, tv[i]);

        // hand-written: 0x99 must never have surfaced; overflow cleared by reset
        checks++;
        if (overflow !== 1'b0 || Load_Reg !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: got ovf=%b load=%b, expected 0 0", overflow, Load_Reg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // 0x99 was pushed only into a full FIFO, so it must never reach the holding register
    always @(negedge clk) begin
        if (Load_Reg === 1'b1 && data_out === 8'h99) begin
            checks++;
            failures++;
            $display("FAIL dropped_value_seen: got data_out=%h, expected never 99", data_out);
        end
    end

endmodule
